// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: stall-controller state encodings and the
// hard-wired zero register number, also used by the forwarding unit.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MULTI_STALL = 2'd1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Hazard-unit bundle: ID/EX hazard sources in, pipeline control out.
// master drives the hazard sources, slave is the stall controller.
interface hazard_stall_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    import hazard_stall_unit_pkg::*;

    logic [REG_W-1:0] IFID_RegisterRs;
    logic [REG_W-1:0] IFID_RegisterRt;
    logic             IFID_UsesRt;
    logic             IDEX_MemRead;
    logic [REG_W-1:0] IDEX_RegisterRt;
    logic             ID_MultiStart;
    logic             EX_BranchTaken;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEX_Bubble;
    logic             IFID_Flush;
    logic             IDEX_Flush;
    logic             Stall_Busy;
    logic [CNT_W-1:0] Stall_Count;

    modport master (
        output IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRt,
        output IDEX_MemRead, IDEX_RegisterRt,
        output ID_MultiStart, EX_BranchTaken,
        input  PCWrite, IFIDWrite, IDEX_Bubble,
        input  IFID_Flush, IDEX_Flush,
        input  Stall_Busy, Stall_Count
    );

    modport slave (
        input  IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRt,
        input  IDEX_MemRead, IDEX_RegisterRt,
        input  ID_MultiStart, EX_BranchTaken,
        output PCWrite, IFIDWrite, IDEX_Bubble,
        output IFID_Flush, IDEX_Flush,
        output Stall_Busy, Stall_Count
    );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter: q increments on each clock with inc=1 and
// sticks at all-ones. Ports: clk, rst_n (async low), inc, q[W].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for load-use, multi-cycle EX ops and taken branches.
// Ports: Clk, Reset (async low), hz (slave: hazard sources in, controls out).
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    hazard_stall_unit_if.slave  hz
);

    localparam int CW = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic pc_write;
    logic ifid_write;
    logic bubble;
    logic flush;
    logic busy;
    logic load_use;

    // Register 0 is hard-wired, so a load into it never creates a hazard.
    always_comb begin
        load_use = hz.IDEX_MemRead
            && (hz.IDEX_RegisterRt != REG_W'(REG_ZERO))
            && ((hz.IDEX_RegisterRt == hz.IFID_RegisterRs)
                || (hz.IFID_UsesRt
                    && (hz.IDEX_RegisterRt == hz.IFID_RegisterRt)));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        bubble     = 1'b0;
        flush      = 1'b0;
        busy       = 1'b0;
        if (Reset) begin
            busy = (state_q == MULTI_STALL);
            if (hz.EX_BranchTaken) begin
                // Wrong-path instrs are squashed; any stall is abandoned.
                flush   = 1'b1;
                state_d = RUN;
                cnt_d   = '0;
            end else if (state_q == MULTI_STALL) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                bubble     = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                bubble     = 1'b1;
            end else if (hz.ID_MultiStart) begin
                // Issue cycle itself is not a stall; EX holds MULTI_LAT-1 more.
                state_d = MULTI_STALL;
                cnt_d   = CW'(MULTI_LAT - 2);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .inc   (~pc_write),
        .q     (hz.Stall_Count)
    );

    assign hz.PCWrite     = pc_write;
    assign hz.IFIDWrite   = ifid_write;
    assign hz.IDEX_Bubble = bubble;
    assign hz.IFID_Flush  = flush;
    assign hz.IDEX_Flush  = flush;
    assign hz.Stall_Busy  = busy;

endmodule
